im_loader: RTL

Program loader that drives the write port of the instruction memory (IM) from a byte stream, holding the processor in reset while it loads. It parses a framed image (16-bit word count, big-endian 16-bit instruction words, XOR checksum) and issues one-cycle IM write pulses at consecutive addresses. It releases `cpu_reset` only after a verified image. It sits between a byte source (UART receiver or bench) and the IM `en_write`/`address`/`data_in` inputs, and gates the PC reset.

---
 rtl/im_loader_if.sv | 29 ++
 rtl/im_loader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/im_loader_if.sv
// Byte-stream / IM write-port / status bundle of the program loader.
// master = byte source and status consumer, slave = the loader itself.
interface im_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  im_en_write;
  logic [ADDR_WIDTH-1:0] im_address;
  logic [15:0]           im_data_in;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, im_en_write, im_address, im_data_in,
    input  cpu_reset, busy, done, error
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, im_en_write, im_address, im_data_in,
    output cpu_reset, busy, done, error
  );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory program loader: parses a framed byte stream
// (16-bit big-endian word count, big-endian words, XOR checksum), writes
// the words to consecutive IM addresses and keeps the CPU in reset until
// a verified image is present.
module im_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input logic      clk,
  input logic      reset,
  im_loader_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
    S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  // Capacity in words; a 17-bit compare so count = 2^ADDR_WIDTH is legal.
  localparam logic [16:0]           CAP  = 17'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_t                r_state;
  logic [7:0]            r_len_hi;
  logic [16:0]           r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_data;
  logic [7:0]            r_csum;
  logic                  r_en_write;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;

  logic                  w_ready;
  logic                  w_idle_like;
  logic                  w_take;
  logic [16:0]           w_len;

  // Handshake and busy are decoded from the registered state only.
  always_comb begin
    w_ready     = (r_state == S_LEN_HI)  || (r_state == S_LEN_LO) ||
                  (r_state == S_DATA_HI) || (r_state == S_DATA_LO) ||
                  (r_state == S_CHECK);
    w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) ||
                  (r_state == S_ERROR);
    w_take      = w_ready && bus.byte_valid;
    w_len       = {1'b0, r_len_hi, bus.byte_data};
  end

  // Frame parser, write-pulse generator and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len_hi    <= 8'h00;
      r_count     <= 17'd0;
      r_addr      <= BASE;
      r_data      <= 16'h0000;
      r_csum      <= 8'h00;
      r_en_write  <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            r_state     <= S_LEN_HI;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_csum      <= 8'h00;
            r_addr      <= BASE;
            r_cpu_reset <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (w_take) begin
            r_len_hi <= bus.byte_data;
            r_csum   <= r_csum ^ bus.byte_data;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_take) begin
            r_count <= w_len;
            r_csum  <= r_csum ^ bus.byte_data;
            if (w_len > CAP) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else if (w_len == 17'd0) begin
              r_state <= S_CHECK;
            end else begin
              r_state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (w_take) begin
            r_data[15:8] <= bus.byte_data;
            r_csum       <= r_csum ^ bus.byte_data;
            r_state      <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (w_take) begin
            r_data[7:0] <= bus.byte_data;
            r_csum      <= r_csum ^ bus.byte_data;
            r_en_write  <= 1'b1;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Address/data held through this cycle; advance once the pulse ends.
          r_en_write <= 1'b0;
          r_addr     <= r_addr + 1'b1;
          r_count    <= r_count - 17'd1;
          r_state    <= (r_count == 17'd1) ? S_CHECK : S_DATA_HI;
        end
        S_CHECK: begin
          if (w_take) begin
            if (bus.byte_data == r_csum) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state     <= S_ERROR;
              r_error     <= 1'b1;
              r_cpu_reset <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready  = w_ready;
  assign bus.busy        = ~w_idle_like;
  assign bus.im_en_write = r_en_write;
  assign bus.im_address  = r_addr;
  assign bus.im_data_in  = r_data;
  assign bus.cpu_reset   = r_cpu_reset;
  assign bus.done        = r_done;
  assign bus.error       = r_error;

endmodule
